sbox_log_lut_pipe: RTL and testbench

SBOX_LOG_LUT_PIPE -- requirements
Module: sbox_log_lut_pipe

---
 rtl/sbox_pkg.sv | 72 +++++++
 rtl/gf256_log_exp_rom.sv | 14 +
 rtl/sbox_log_lut_pipe.sv | 118 +++++++++++
 tb/tb_sbox_log_lut_pipe.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbox_pkg.sv
// Shared GF(2^8) constants, log/exp table builders and the AES affine maps
// used by the pipelined log/antilog S-box.
package sbox_pkg;

  localparam logic [8:0] AES_POLY  = 9'h11B;
  localparam logic [7:0] GEN       = 8'h03;
  localparam logic [7:0] AFF_C     = 8'h63;
  localparam logic [7:0] INV_AFF_C = 8'h05;
  localparam int         MAX_LANES = 16;

  typedef logic [255:0][7:0] gf_table_t;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY[7:0] : 8'h00);
  endfunction

  // The generator only has bits 0/1 set, so a multiply is x*1 ^ x*2.
  function automatic logic [7:0] gf_mul_gen(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    if (GEN[0]) r = r ^ a;
    if (GEN[1]) r = r ^ gf_xtime(a);
    return r;
  endfunction

  function automatic gf_table_t build_exp_table();
    gf_table_t  t;
    logic [7:0] v;
    t = '0;
    v = 8'h01;
    for (int i = 0; i < 256; i++) begin
      t[i[7:0]] = v;
      v         = gf_mul_gen(v);
    end
    return t;
  endfunction

  // Entry 0 is a don't-care: zero is handled by a separate flag.
  function automatic gf_table_t build_log_table();
    gf_table_t  t;
    logic [7:0] v;
    t = '0;
    v = 8'h01;
    for (int i = 0; i < 255; i++) begin
      t[v] = i[7:0];
      v    = gf_mul_gen(v);
    end
    return t;
  endfunction

  localparam gf_table_t EXP_TABLE = build_exp_table();
  localparam gf_table_t LOG_TABLE = build_log_table();

  // b'_i = b_i ^ b_(i+4) ^ b_(i+5) ^ b_(i+6) ^ b_(i+7) ^ c_i, written as rotations.
  function automatic logic [7:0] aff_fwd(input logic [7:0] b);
    return b
         ^ {b[6:0], b[7]}
         ^ {b[5:0], b[7:6]}
         ^ {b[4:0], b[7:5]}
         ^ {b[3:0], b[7:4]}
         ^ AFF_C;
  endfunction

  // b'_i = b_(i+2) ^ b_(i+5) ^ b_(i+7) ^ d_i
  function automatic logic [7:0] aff_inv(input logic [7:0] b);
    return {b[1:0], b[7:2]}
         ^ {b[4:0], b[7:5]}
         ^ {b[6:0], b[7]}
         ^ INV_AFF_C;
  endfunction

endpackage

// File: rtl/gf256_log_exp_rom.sv
// Combinational GF(2^8) log and antilog lookup pair for a single byte lane.
module gf256_log_exp_rom
  import sbox_pkg::*;
(
  input  logic [7:0] i_log_addr,
  output logic [7:0] o_log,
  input  logic [7:0] i_exp_addr,
  output logic [7:0] o_exp
);

  assign o_log = LOG_TABLE[i_log_addr];
  assign o_exp = EXP_TABLE[i_exp_addr];

endmodule

// File: rtl/sbox_log_lut_pipe.sv
// Three-stage multi-lane AES S-box / inverse S-box built from GF(2^8)
// log/antilog tables, with valid/ready flow control and a shared stall.
module sbox_log_lut_pipe
  import sbox_pkg::*;
#(
  parameter int LANES           = 4,
  parameter bit FULL_THROUGHPUT = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic                 in_encrypt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 busy
);

  localparam int W = 8 * LANES;

  logic             r_s1_valid;
  logic             r_s2_valid;
  logic             r_out_valid;
  logic             r_s1_enc;
  logic             r_s2_enc;
  logic [W-1:0]     r_s1_data;
  logic [W-1:0]     r_s2_log;
  logic [LANES-1:0] r_s2_zero;
  logic [W-1:0]     r_out_data;

  logic             w_advance;
  logic             w_accept;
  logic [W-1:0]     w_s1_next;
  logic [W-1:0]     w_log;
  logic [LANES-1:0] w_zero;
  logic [W-1:0]     w_exp_addr;
  logic [W-1:0]     w_exp;
  logic [W-1:0]     w_result;

  assign w_advance = !r_out_valid || out_ready;
  assign busy      = r_s1_valid || r_s2_valid || r_out_valid;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  generate
    if (FULL_THROUGHPUT) begin : g_full
      assign in_ready = reset_n && (!r_s1_valid || w_advance);
    end else begin : g_area
      assign in_ready = reset_n && !busy;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < MAX_LANES; gi++) begin : g_lane
      if (gi < LANES) begin : g_on
        logic [8:0] w_sum;
        logic [8:0] w_wrap;
        logic [7:0] w_inv;

        assign w_s1_next[8*gi +: 8] = in_encrypt ? in_data[8*gi +: 8]
                                                 : aff_inv(in_data[8*gi +: 8]);
        assign w_zero[gi] = (r_s1_data[8*gi +: 8] == 8'h00);

        // (255 - log) mod 255; only log == 0 lands on 255 and wraps to 0.
        assign w_sum  = 9'd255 - {1'b0, r_s2_log[8*gi +: 8]};
        assign w_wrap = w_sum - 9'd255;
        assign w_exp_addr[8*gi +: 8] = (w_sum >= 9'd255) ? w_wrap[7:0] : w_sum[7:0];

        gf256_log_exp_rom u_rom (
          .i_log_addr (r_s1_data[8*gi +: 8]),
          .o_log      (w_log[8*gi +: 8]),
          .i_exp_addr (w_exp_addr[8*gi +: 8]),
          .o_exp      (w_exp[8*gi +: 8])
        );

        assign w_inv = r_s2_zero[gi] ? 8'h00 : w_exp[8*gi +: 8];
        assign w_result[8*gi +: 8] = r_s2_enc ? aff_fwd(w_inv) : w_inv;
      end
    end
  endgenerate

  // Control state: S1 may fill while stalled if it is empty; S2/S3 move only on advance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_advance || !r_s1_valid) begin
        r_s1_valid <= w_accept;
      end
      if (w_advance) begin
        r_s2_valid  <= r_s1_valid;
        r_out_valid <= r_s2_valid;
        if (r_s2_valid) begin
          r_out_data <= w_result;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_data <= w_s1_next;
      r_s1_enc  <= in_encrypt;
    end
    if (w_advance && r_s1_valid) begin
      r_s2_log  <= w_log;
      r_s2_zero <= w_zero;
      r_s2_enc  <= r_s1_enc;
    end
  end

endmodule

// File: tb/tb_sbox_log_lut_pipe.sv
// Scoreboard bench: a full-throughput instance for directed/stream/stall/reset
// sequences and an area-mode instance for the exhaustive byte sweep.
module tb_sbox_log_lut_pipe;

  localparam int LANES = 4;
  localparam int W     = 8 * LANES;

  localparam logic [127:0] SBOX_ROWS [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         a_in_valid, a_in_ready, a_in_encrypt, a_out_valid, a_out_ready, a_busy;
  logic [W-1:0] a_in_data, a_out_data;
  logic         b_in_valid, b_in_ready, b_in_encrypt, b_out_valid, b_out_ready, b_busy;
  logic [W-1:0] b_in_data, b_out_data;

  sbox_log_lut_pipe #(.LANES(LANES), .FULL_THROUGHPUT(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_encrypt(a_in_encrypt), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .busy(a_busy)
  );

  sbox_log_lut_pipe #(.LANES(LANES), .FULL_THROUGHPUT(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_encrypt(b_in_encrypt), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .busy(b_busy)
  );

  typedef struct {
    logic [W-1:0] din;
    logic         enc;
    logic [W-1:0] dout;
  } vec_t;

  vec_t         vecs [6];
  logic [7:0]   sbox     [256];
  logic [7:0]   inv_sbox [256];
  logic [W-1:0] q_a [$];
  logic [W-1:0] q_b [$];
  int           total  = 0;
  int           bad    = 0;
  int           pops_a = 0;
  int           pops_b = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] golden(input logic [W-1:0] d, input logic enc);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      r[8*i +: 8] = enc ? sbox[d[8*i +: 8]] : inv_sbox[d[8*i +: 8]];
    end
    return r;
  endfunction

  // Offers a word (called just after a negedge); pushes the expectation once in_ready is seen.
  task automatic send(input bit to_b, input logic [W-1:0] d, input logic enc,
                      input logic [W-1:0] exp, output int waits);
    logic rdy;
    waits = 0;
    if (to_b) begin
      b_in_valid = 1'b1; b_in_data = d; b_in_encrypt = enc;
    end else begin
      a_in_valid = 1'b1; a_in_data = d; a_in_encrypt = enc;
    end
    #1;
    rdy = to_b ? b_in_ready : a_in_ready;
    while (!rdy && waits < 50) begin
      @(negedge clk);
      #1;
      waits++;
      rdy = to_b ? b_in_ready : a_in_ready;
    end
    if (rdy) begin
      if (to_b) q_b.push_back(exp);
      else      q_a.push_back(exp);
    end else begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1 within 50 cycles");
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (reset_n === 1'b1 && a_out_valid && a_out_ready) begin : mon_a
      logic [W-1:0] e;
      if (q_a.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_unexpected: got %h want no output", a_out_data);
      end else begin
        e = q_a.pop_front();
        pops_a++;
        $display("txn A %0d: got %h exp %h", pops_a, a_out_data, e);
        check("a_data", a_out_data, e);
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (reset_n === 1'b1 && b_out_valid && b_out_ready) begin : mon_b
      logic [W-1:0] e;
      if (q_b.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected: got %h want no output", b_out_data);
      end else begin
        e = q_b.pop_front();
        pops_b++;
        $display("txn B %0d: got %h exp %h", pops_b, b_out_data, e);
        check("b_data", b_out_data, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] row;
    logic [W-1:0] d, held;
    logic [7:0]   bb;
    logic         enc;
    int           w, lat, base;

    for (int r = 0; r < 16; r++) begin
      row = SBOX_ROWS[r];
      for (int c = 0; c < 16; c++) sbox[16*r + c] = row[127 - 8*c -: 8];
    end
    for (int i = 0; i < 256; i++) inv_sbox[sbox[i]] = i[7:0];

    vecs[0] = '{din: 32'h000153FF, enc: 1'b1, dout: 32'h637CED16};
    vecs[1] = '{din: 32'h637CED16, enc: 1'b0, dout: 32'h000153FF};
    vecs[2] = '{din: 32'h00000000, enc: 1'b0, dout: 32'h52525252};
    vecs[3] = '{din: 32'h00000000, enc: 1'b1, dout: 32'h63636363};
    vecs[4] = '{din: 32'h10111213, enc: 1'b1, dout: 32'hCA82C97D};
    vecs[5] = '{din: 32'hCA82C97D, enc: 1'b0, dout: 32'h10111213};

    reset_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_encrypt = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_encrypt = 1'b0; b_out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", a_out_valid, 0);
    check("rst_busy",      a_busy,      0);
    check("rst_out_data",  a_out_data,  0);
    check("rst_in_ready",  a_in_ready,  0);
    check("rst_b_in_ready", b_in_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_rst_in_ready",   a_in_ready, 1);
    check("post_rst_b_in_ready", b_in_ready, 1);

    // Directed vectors, each with a latency measurement
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      send(1'b0, vecs[v].din, vecs[v].enc, vecs[v].dout, w);
      check("vec_wait", w, 0);
      lat = 0;
      do begin
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        lat++;
      end while (!a_out_valid && lat < 10);
      check("vec_latency", lat, 3);
    end
    repeat (2) @(negedge clk);
    #1;
    check("idle_out_valid", a_out_valid, 0);
    check("idle_out_hold",  a_out_data,  vecs[5].dout);

    // 20 back-to-back words, alternating modes
    base = pops_a;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      d   = $urandom;
      enc = (k % 2 == 0);
      send(1'b0, d, enc, golden(d, enc), w);
      check("b2b_ready", w, 0);
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check("b2b_count", pops_a - base, 20);

    // Fill the pipe, then hold out_ready low for 5 cycles
    @(negedge clk);
    a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge clk);
      d   = $urandom;
      enc = (k != 1);
      send(1'b0, d, enc, golden(d, enc), w);
      check("stall_fill_wait", w, 0);
    end
    @(negedge clk);
    d = $urandom;
    a_in_valid = 1'b1; a_in_data = d; a_in_encrypt = 1'b0;
    #1;
    check("stall_out_valid", a_out_valid, 1);
    held = a_out_data;
    repeat (5) begin
      check("stall_in_ready", a_in_ready, 0);
      check("stall_hold",     a_out_data, held);
      check("stall_valid",    a_out_valid, 1);
      @(negedge clk);
      #1;
    end
    a_out_ready = 1'b1;
    send(1'b0, d, 1'b0, golden(d, 1'b0), w);
    check("stall_release_wait", w, 0);
    @(negedge clk);
    a_in_valid = 1'b0;
    lat = 0;
    while (q_a.size() != 0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    #3;
    check("stall_drain", q_a.size(), 0);

    // Reset pulse with three words in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      d = $urandom;
      send(1'b0, d, 1'b1, golden(d, 1'b1), w);
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    reset_n = 1'b0;
    q_a.delete();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("midrst_out_valid", a_out_valid, 0);
    check("midrst_busy",      a_busy,      0);
    check("midrst_in_ready",  a_in_ready,  1);
    repeat (6) begin
      @(negedge clk);
      #1;
      check("midrst_no_stale", a_out_valid, 0);
    end
    @(negedge clk);
    d = 32'h53005300;
    send(1'b0, d, 1'b1, 32'hED63ED63, w);
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    check("midrst_recover", q_a.size(), 0);

    // Area mode: exhaustive sweep in both modes
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      enc = (k < 64);
      bb  = 8'((k % 64) * 4);
      d   = {bb + 8'd3, bb + 8'd2, bb + 8'd1, bb};
      send(1'b1, d, enc, golden(d, enc), w);
      check("ft0_ready_gap", w, (k == 0) ? 0 : 3);
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    lat = 0;
    while (q_b.size() != 0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    #3;
    check("ft0_drain",   q_b.size(), 0);
    check("ft0_count",   pops_b, 128);
    check("a_q_empty",   q_a.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
